// File: rtl/dyn_add_sequencer.sv
// Issue/collect stage around adder_16: accept -> out_valid after N+2 edges, N predicted from propagate pairs.
// One op in flight; in_ready drops while busy or the result FIFO is full; FIFO head holds under out_ready=0.
module dyn_add_sequencer #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 2,
  parameter int BASE_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  output logic             add_f,
  output logic             add_request,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(BASE_WAIT + 4) + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, CAPTURE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_mem_q [DEPTH];
  logic             cout_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             accept, push, pop;
  logic             k2, k1, k0;
  logic [CNT_W-1:0] n_pred;

  // Each adjacent propagate pair can extend the carry chain by one extra cycle.
  assign k2     = (in_a[12] ^ in_b[12]) & (in_a[11] ^ in_b[11]);
  assign k1     = (in_a[8] ^ in_b[8]) & (in_a[7] ^ in_b[7]);
  assign k0     = (in_a[4] ^ in_b[4]) & (in_a[3] ^ in_b[3]);
  assign n_pred = CNT_W'(BASE_WAIT) + CNT_W'(k2) + CNT_W'(k1) + CNT_W'(k0);

  assign in_ready  = (state_q == IDLE) && (occ_q < OCC_W'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_sum   = sum_mem_q[rd_ptr_q];
  assign out_cout  = cout_mem_q[rd_ptr_q];
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_cin   = cin_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    add_f       = 1'b0;
    add_request = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        add_f = 1'b1;
        if (accept) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          cnt_d   = n_pred;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        add_f   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = CAPTURE;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      CAPTURE: begin
        add_request = 1'b1;
        push        = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
    end
  end

  // Result FIFO; in_ready gating guarantees push never lands on a full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sum_mem_q[i]  <= '0;
        cout_mem_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        sum_mem_q[wr_ptr_q]  <= add_sum;
        cout_mem_q[wr_ptr_q] <= add_cout;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      occ_q <= occ_q + 1'b1;
      else if (pop && !push) occ_q <= occ_q - 1'b1;
    end
  end

endmodule
